a4a13_timing_gen: RTL



---
 rtl/lvdc_timing_pkg.sv | 17 +
 rtl/lvdc_mod_counter.sv | 40 ++++
 rtl/a4a13_timing_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/lvdc_timing_pkg.sv
// Shared time-base constants and controller state type for the serial-computer timing generator.
package lvdc_timing_pkg;

  localparam int unsigned CLK_PER_BIT_DEF      = 4;
  localparam int unsigned BITS_PER_PHASE_DEF   = 14;
  localparam int unsigned PHASES_PER_CYCLE_DEF = 3;
  localparam int unsigned CYCLE_CLOCKS         =
      CLK_PER_BIT_DEF * BITS_PER_PHASE_DEF * PHASES_PER_CYCLE_DEF;

  typedef enum logic [1:0] {
    StHalted  = 2'd0,
    StRun     = 2'd1,
    StHalting = 2'd2,
    StStep    = 2'd3
  } tg_state_t;

endpackage

// File: rtl/lvdc_mod_counter.sv
// Enable/wrap counter running 1..Max with a terminal-count flag; clear forces it back to 1.
module lvdc_mod_counter #(
  parameter int unsigned Width = 4,
  parameter int unsigned Max   = 14
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);
  localparam logic [Width-1:0] OneVal = Width'(1);

  logic [Width-1:0] count_q, count_d;

  assign tc_o    = (count_q == MaxVal);
  assign count_o = count_q;

  // Out-of-range values (upset) restart the count rather than propagate.
  always_comb begin
    count_d = count_q;
    if (clr_i || (count_q == '0) || (count_q > MaxVal)) begin
      count_d = OneVal;
    end else if (en_i) begin
      count_d = tc_o ? OneVal : count_q + OneVal;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= OneVal;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/a4a13_timing_gen.sv
// Serial-computer time base: sub-bit ring, bit-time and phase counters, and run/halt/step control
// that only ever stops on an instruction-cycle boundary.
module a4a13_timing_gen
  import lvdc_timing_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT      = CLK_PER_BIT_DEF,
  parameter int unsigned BITS_PER_PHASE   = BITS_PER_PHASE_DEF,
  parameter int unsigned PHASES_PER_CYCLE = PHASES_PER_CYCLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_req,
  input  logic                   step_req,
  output logic [CLK_PER_BIT-1:0] sub_bit,
  output logic [3:0]             bit_time,
  output logic [1:0]             phase,
  output logic                   bit_strobe,
  output logic                   phase_strobe,
  output logic                   cycle_end,
  output logic                   halted,
  output logic                   busy
);

  localparam logic [CLK_PER_BIT-1:0] SubBitStart = CLK_PER_BIT'(1);

  tg_state_t              state_q, state_d;
  logic [CLK_PER_BIT-1:0] sub_bit_q, sub_bit_d;
  logic                   advancing;
  logic                   bit_tc, phase_tc;

  assign advancing = (state_q != StHalted);

  // Strobes decode registered state only, so they are glitch-free.
  assign bit_strobe   = advancing & sub_bit_q[CLK_PER_BIT-1];
  assign phase_strobe = bit_strobe & bit_tc;
  assign cycle_end    = phase_strobe & phase_tc;

  assign sub_bit = sub_bit_q;
  assign halted  = (state_q == StHalted);
  assign busy    = advancing;

  always_comb begin
    sub_bit_d = SubBitStart;
    if (advancing && $onehot(sub_bit_q)) begin
      sub_bit_d = {sub_bit_q[CLK_PER_BIT-2:0], sub_bit_q[CLK_PER_BIT-1]};
    end
  end

  lvdc_mod_counter #(
    .Width (4),
    .Max   (BITS_PER_PHASE)
  ) u_bit_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (bit_strobe),
    .clr_i   (!advancing),
    .count_o (bit_time),
    .tc_o    (bit_tc)
  );

  lvdc_mod_counter #(
    .Width (2),
    .Max   (PHASES_PER_CYCLE)
  ) u_phase_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (phase_strobe),
    .clr_i   (!advancing),
    .count_o (phase),
    .tc_o    (phase_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalted: begin
        if (run_req) begin
          state_d = StRun;
        end else if (step_req) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (!run_req) begin
          state_d = StHalting;
        end
      end
      StHalting: begin
        if (run_req) begin
          state_d = StRun;
        end else if (cycle_end) begin
          state_d = StHalted;
        end
      end
      StStep: begin
        if (cycle_end) begin
          state_d = run_req ? StRun : StHalted;
        end
      end
      default: state_d = StHalted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHalted;
      sub_bit_q <= SubBitStart;
    end else begin
      state_q   <= state_d;
      sub_bit_q <= sub_bit_d;
    end
  end

endmodule
